// File: rtl/led_matrix_scan_ctrl.sv
// Column scan controller for a multiplexed LED matrix.
// Each column gets BLANK_CYCLES of all-off time (so the row mux settles) and is then driven for DIV cycles.
module led_matrix_scan_ctrl #(
  parameter int NUM_COLS     = 5,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic [2:0]          col_sel,
  output logic [NUM_COLS-1:0] col_en_n,
  output logic                frame_start,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] DRIVE_LAST = 16'(DIV - 1);
  localparam logic [2:0]  LAST_COL   = 3'(NUM_COLS - 1);

  state_t                state, state_nxt;
  logic [15:0]           cnt, cnt_nxt;
  logic [2:0]            idx, idx_nxt;
  logic                  fs_nxt;
  logic [NUM_COLS-1:0]   col_en_n_nxt;

  // Outputs are registered from the next-state values, so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      idx         <= 3'd0;
      col_en_n    <= '1;
      col_sel     <= 3'd0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      col_en_n    <= col_en_n_nxt;
      col_sel     <= idx_nxt;
      frame_start <= fs_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    fs_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        idx_nxt = 3'd0;
        if (enable) begin
          state_nxt = BLANK;
          fs_nxt    = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          idx_nxt   = 3'd0;
        end else if (cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          idx_nxt   = 3'd0;
        end else if (cnt == DRIVE_LAST) begin
          // Column advance happens only on entry to BLANK, keeping col_sel stable while driving.
          state_nxt = BLANK;
          cnt_nxt   = 16'd0;
          if (idx == LAST_COL) begin
            idx_nxt = 3'd0;
            fs_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    col_en_n_nxt = '1;
    if (state_nxt == DRIVE) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (idx_nxt == 3'(i)) col_en_n_nxt[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench: three parameterisations share stimulus and are checked against a
// time-since-start arithmetic model, plus a constant vector table and hand-written corner sequences.
module tb_led_matrix_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  logic [2:0] a_sel, b_sel, c_sel;
  logic [4:0] a_en_n, b_en_n;
  logic [2:0] c_en_n;
  logic a_fs, b_fs, c_fs, a_busy, b_busy, c_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit inv_on = 1'b0;
  bit mdl_running = 1'b0;
  int mdl_t = 0;
  logic [2:0] prev_a_sel = 3'd0, prev_b_sel = 3'd0, prev_c_sel = 3'd0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [4:0] en_n;
    logic [2:0] sel;
    logic       fs;
    logic       busy;
  } vec_t;

  vec_t tbl[16];

  led_matrix_scan_ctrl #(.NUM_COLS(5), .DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .col_sel(a_sel), .col_en_n(a_en_n), .frame_start(a_fs), .busy(a_busy));

  led_matrix_scan_ctrl #(.NUM_COLS(5), .DIV(1), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .col_sel(b_sel), .col_en_n(b_en_n), .frame_start(b_fs), .busy(b_busy));

  led_matrix_scan_ctrl #(.NUM_COLS(3), .DIV(2), .BLANK_CYCLES(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .col_sel(c_sel), .col_en_n(c_en_n), .frame_start(c_fs), .busy(c_busy));

  always #5 clk = ~clk;

  task automatic checkField(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs from the scan rules: t counts cycles since the first BLANK of the scan.
  function automatic void expected(input int n, input int d, input int b,
                                   output logic [7:0] en, output logic [2:0] sel,
                                   output logic fs, output logic bsy);
    int p, ph, col;
    en = 8'hFF; sel = 3'd0; fs = 1'b0; bsy = 1'b0;
    if (mdl_running) begin
      p   = b + d;
      ph  = mdl_t % p;
      col = (mdl_t / p) % n;
      sel = 3'(col);
      fs  = ((mdl_t % (n * p)) == 0);
      bsy = 1'b1;
      if (ph >= b) en[col] = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic e);
    rst_n  = r;
    enable = e;
    @(posedge clk);
    #1;
    cyc++;
    if (!r || !e) mdl_running = 1'b0;
    else if (!mdl_running) begin
      mdl_running = 1'b1;
      mdl_t = 0;
    end else mdl_t++;
  endtask

  task automatic checkOutput();
    logic [7:0] en;
    logic [2:0] sel;
    logic fs, bsy;
    expected(5, 4, 1, en, sel, fs, bsy);
    checkField("A col_en_n", {3'b111, a_en_n}, en);
    checkField("A col_sel", {5'd0, a_sel}, {5'd0, sel});
    checkField("A frame_start", {7'd0, a_fs}, {7'd0, fs});
    checkField("A busy", {7'd0, a_busy}, {7'd0, bsy});
    expected(5, 1, 1, en, sel, fs, bsy);
    checkField("B col_en_n", {3'b111, b_en_n}, en);
    checkField("B col_sel", {5'd0, b_sel}, {5'd0, sel});
    checkField("B frame_start", {7'd0, b_fs}, {7'd0, fs});
    checkField("B busy", {7'd0, b_busy}, {7'd0, bsy});
    expected(3, 2, 3, en, sel, fs, bsy);
    checkField("C col_en_n", {5'b11111, c_en_n}, en);
    checkField("C col_sel", {5'd0, c_sel}, {5'd0, sel});
    checkField("C frame_start", {7'd0, c_fs}, {7'd0, fs});
    checkField("C busy", {7'd0, c_busy}, {7'd0, bsy});
  endtask

  task automatic checkInv(input string nm, input logic [7:0] en, input logic [2:0] sel,
                          input logic [2:0] prev);
    checks++;
    if ($countones(~en) > 1) begin
      errors++;
      $display("[TB] FAIL %s one-hot at cycle %0d: col_en_n %0b has several low bits", nm, cyc, en);
    end
    if (en != 8'hFF) begin
      checks++;
      if (sel !== prev) begin
        errors++;
        $display("[TB] FAIL %s col_sel stable at cycle %0d: got %0d, expected %0d", nm, cyc, sel, prev);
      end
    end
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      checkInv("A", {3'b111, a_en_n}, a_sel, prev_a_sel);
      checkInv("B", {3'b111, b_en_n}, b_sel, prev_b_sel);
      checkInv("C", {5'b11111, c_en_n}, c_sel, prev_c_sel);
    end
    prev_a_sel = a_sel;
    prev_b_sel = b_sel;
    prev_c_sel = c_sel;
  end

  task automatic setVec(input int i, input logic r, input logic e, input logic [4:0] en_n,
                        input logic [2:0] sel, input logic fs, input logic bsy);
    tbl[i].rst_n = r;
    tbl[i].en    = e;
    tbl[i].en_n  = en_n;
    tbl[i].sel   = sel;
    tbl[i].fs    = fs;
    tbl[i].busy  = bsy;
  endtask

  task automatic runTo(input int target);
    int guard = 0;
    while (mdl_t != target && guard < 200) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput();
      guard++;
    end
    checkField("runTo reached", {7'd0, (mdl_t == target)}, 8'd1);
  endtask

  initial begin
    int last_a, last_b, last_c;
    logic r, e;

    setVec(0,  1'b0, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0);
    setVec(1,  1'b0, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0);
    setVec(2,  1'b1, 1'b1, 5'b11111, 3'd0, 1'b1, 1'b1);
    for (int i = 3; i <= 6; i++) setVec(i, 1'b1, 1'b1, 5'b11110, 3'd0, 1'b0, 1'b1);
    setVec(7,  1'b1, 1'b1, 5'b11111, 3'd1, 1'b0, 1'b1);
    for (int i = 8; i <= 11; i++) setVec(i, 1'b1, 1'b1, 5'b11101, 3'd1, 1'b0, 1'b1);
    setVec(12, 1'b1, 1'b1, 5'b11111, 3'd2, 1'b0, 1'b1);
    setVec(13, 1'b1, 1'b1, 5'b11011, 3'd2, 1'b0, 1'b1);
    setVec(14, 1'b1, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0);
    setVec(15, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].en);
      if (i == 1) inv_on = 1'b1;
      checkOutput();
      checkField($sformatf("vec%0d col_en_n", i), {3'd0, a_en_n}, {3'd0, tbl[i].en_n});
      checkField($sformatf("vec%0d col_sel", i), {5'd0, a_sel}, {5'd0, tbl[i].sel});
      checkField($sformatf("vec%0d frame_start", i), {7'd0, a_fs}, {7'd0, tbl[i].fs});
      checkField($sformatf("vec%0d busy", i), {7'd0, a_busy}, {7'd0, tbl[i].busy});
    end

    // Abort during DRIVE of column 2, then restart.
    runTo(12);
    checkField("abort pre col_en_n", {3'd0, a_en_n}, 8'b0001_1011);
    applyStimulus(1'b1, 1'b0);
    checkField("abort col_en_n", {3'd0, a_en_n}, 8'b0001_1111);
    checkField("abort col_sel", {5'd0, a_sel}, 8'd0);
    checkField("abort busy", {7'd0, a_busy}, 8'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    checkField("restart frame_start", {7'd0, a_fs}, 8'd1);
    checkField("restart col_sel", {5'd0, a_sel}, 8'd0);
    applyStimulus(1'b1, 1'b1);
    checkField("restart col_en_n", {3'd0, a_en_n}, 8'b0001_1110);

    // Reset in the middle of column 3 with enable held high.
    runTo(17);
    checkField("reset pre col_en_n", {3'd0, a_en_n}, 8'b0001_0111);
    applyStimulus(1'b0, 1'b1);
    checkOutput();
    checkField("reset col_en_n", {3'd0, a_en_n}, 8'b0001_1111);
    checkField("reset busy", {7'd0, a_busy}, 8'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    checkField("post-reset frame_start", {7'd0, a_fs}, 8'd1);
    checkField("post-reset col_sel", {5'd0, a_sel}, 8'd0);

    // Wrap from the last column back to column 0.
    runTo(24);
    checkField("wrap pre col_sel", {5'd0, a_sel}, 8'd4);
    checkField("wrap pre col_en_n", {3'd0, a_en_n}, 8'b0000_1111);
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    checkField("wrap col_sel", {5'd0, a_sel}, 8'd0);
    checkField("wrap frame_start", {7'd0, a_fs}, 8'd1);

    // Full frames with frame_start spacing for each parameterisation.
    applyStimulus(1'b1, 1'b0);
    checkOutput();
    last_a = -1; last_b = -1; last_c = -1;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput();
      if (a_fs) begin
        if (last_a >= 0) checkField("A frame period", 8'(k - last_a), 8'd25);
        last_a = k;
      end
      if (b_fs) begin
        if (last_b >= 0) checkField("B frame period", 8'(k - last_b), 8'd10);
        last_b = k;
      end
      if (c_fs) begin
        if (last_c >= 0) checkField("C frame period", 8'(k - last_c), 8'd15);
        last_c = k;
      end
    end
    checkField("A frame pulses seen", {7'd0, (last_a == 50)}, 8'd1);
    checkField("B frame pulses seen", {7'd0, (last_b == 50)}, 8'd1);

    // Randomised enable/reset traffic against the model.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(99) >= 2);
      e = ($urandom_range(99) >= 4);
      applyStimulus(r, e);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_COLS, default 5: number of matrix columns scanned; legal range 2..8.
REQ-002 The block SHALL have parameter DIV, default 1000: clock cycles each column is driven; legal range 1..65535.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 2: all-off clock cycles before each column drive; legal range 1..65535.
REQ-004 The block SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-008 The block SHALL have port col_sel, output, 3 bits: binary index of the current column, for the downstream row multiplexers; bit 0 is the 2:1 mux select.
REQ-009 The block SHALL have port col_en_n, output, NUM_COLS bits: active-low one-hot column drive.
REQ-010 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-012 The block SHALL register all outputs, with no combinational path from any input to any output.
REQ-013 The block SHALL implement three states: IDLE, BLANK and DRIVE, with a 16-bit phase counter and a column index idx.
REQ-014 In IDLE the block SHALL hold col_en_n all ones, col_sel=0, idx=0, frame_start=0 and busy=0.
REQ-015 In IDLE with enable=1 sampled, the block SHALL transition to BLANK with idx=0, counter=0 and frame_start=1 for exactly that first BLANK cycle.
REQ-016 In BLANK the block SHALL drive col_en_n all ones and col_sel=idx, so the downstream mux settles before drive.
REQ-017 The block SHALL stay in BLANK for exactly BLANK_CYCLES cycles and then enter DRIVE with counter=0.
REQ-018 In DRIVE the block SHALL drive col_en_n[idx]=0 with all other bits 1, and col_sel=idx.
REQ-019 The block SHALL stay in DRIVE for exactly DIV cycles and then enter BLANK with idx incremented.
REQ-020 When idx=NUM_COLS-1 leaves DRIVE, idx SHALL wrap to 0 and frame_start SHALL pulse for the first BLANK cycle.
REQ-021 Column period SHALL be BLANK_CYCLES+DIV cycles; frame period SHALL be NUM_COLS*(BLANK_CYCLES+DIV) cycles.
REQ-022 At no time SHALL more than one col_en_n bit be low.
REQ-023 col_sel SHALL never change in a cycle where any col_en_n bit is low.
REQ-024 When enable=0 is sampled in BLANK or DRIVE, the block SHALL enter IDLE on that edge with all IDLE output values, and the scan SHALL be abandoned with no completion.
REQ-025 When enable returns to 1, scanning SHALL restart at column 0 with frame_start.
REQ-026 DIV=1 and BLANK_CYCLES=1 SHALL be legal, giving a 2-cycle column period.
REQ-027 Counter compare values SHALL be computed at the 16-bit width without overflow.
REQ-028 The upper bits of col_sel SHALL be 0 when NUM_COLS<=4.

Reset
REQ-029 rst_n=0 sampled on a rising edge SHALL force IDLE, idx=0, counter=0, col_en_n all ones, col_sel=0, frame_start=0 and busy=0, regardless of state or enable.
REQ-030 Reset SHALL take priority over enable; the first scan SHALL begin on the first edge after release with rst_n=1 and enable=1.

Verification (NUM_COLS=5, DIV=4, BLANK_CYCLES=1 unless stated)
REQ-031 Bench SHALL check start: rst_n released, enable=1 -> frame_start high one cycle; then col_en_n=11110 for 4 cycles; col_sel=0 throughout the first 5 cycles.
REQ-032 Bench SHALL check full frame: enable held 60 cycles -> col_en_n sequence 11110, 11101, 11011, 10111, 01111, each held 4 cycles after 1 all-ones cycle; frame_start pulses every 25 cycles.
REQ-033 Bench SHALL check abort: enable dropped during DRIVE of column 2 -> next cycle col_en_n=11111, col_sel=0, busy=0; re-enable -> restart at column 0 with frame_start.
REQ-034 Bench SHALL check mid-scan reset: rst_n=0 during column 3 with enable=1 -> IDLE outputs next cycle; after release, scan restarts at column 0.
REQ-035 Bench SHALL check minimum timing: DIV=1, BLANK_CYCLES=1 -> period of 2 cycles per column and 10 cycles per frame; one-hot and col_sel-stable assertions hold every cycle.
REQ-036 Bench SHALL check wrap: idx=4 finishing DRIVE -> col_sel=0 and frame_start=1 on the following cycle.
